// File: rtl/tdm_demux8.sv
// Eight-slot TDM demultiplexer: hunts for frame_sync, stages slots 0..7, then
// publishes a whole frame to D0..D7 with a one-cycle frame_done pulse.
module tdm_demux8 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] D0,
  output logic [WIDTH-1:0] D1,
  output logic [WIDTH-1:0] D2,
  output logic [WIDTH-1:0] D3,
  output logic [WIDTH-1:0] D4,
  output logic [WIDTH-1:0] D5,
  output logic [WIDTH-1:0] D6,
  output logic [WIDTH-1:0] D7,
  output logic             frame_done,
  output logic [2:0]       sel,
  output logic             locked,
  output logic             sync_error
);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] stage_q [8];
  logic [WIDTH-1:0] stage_d [8];
  logic [WIDTH-1:0] d_q [8];
  logic [WIDTH-1:0] d_d [8];
  logic             frame_done_q, frame_done_d;
  logic             sync_error_q, sync_error_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      sel_q        <= 3'd0;
      stage_q      <= '{default: '0};
      d_q          <= '{default: '0};
      frame_done_q <= 1'b0;
      sync_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      stage_q      <= stage_d;
      d_q          <= d_d;
      frame_done_q <= frame_done_d;
      sync_error_q <= sync_error_d;
    end
  end

  // Beats without din_valid fall through the defaults and change nothing.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    stage_d      = stage_q;
    d_d          = d_q;
    frame_done_d = 1'b0;
    sync_error_d = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            stage_d[0] = din;
            sel_d      = 3'd1;
            state_d    = RECV;
          end
        end
        RECV: begin
          if (sel_q == 3'd0) begin
            if (frame_sync) begin
              stage_d[0] = din;
              sel_d      = 3'd1;
            end else begin
              sync_error_d = 1'b1;
              state_d      = HUNT;
            end
          end else if (frame_sync) begin
            // Early sync: abandon the partial frame and restart at slot 0.
            sync_error_d = 1'b1;
            stage_d[0]   = din;
            sel_d        = 3'd1;
          end else begin
            stage_d[sel_q] = din;
            sel_d          = sel_q + 3'd1;
            if (sel_q == 3'd7) begin
              d_d          = stage_d;
              frame_done_d = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign D0         = d_q[0];
  assign D1         = d_q[1];
  assign D2         = d_q[2];
  assign D3         = d_q[3];
  assign D4         = d_q[4];
  assign D5         = d_q[5];
  assign D6         = d_q[6];
  assign D7         = d_q[7];
  assign frame_done = frame_done_q;
  assign sync_error = sync_error_q;
  assign sel        = sel_q;
  assign locked     = (state_q == RECV);

endmodule

// File: tb/tb_tdm_demux8.sv
// Table-driven check of tdm_demux8 at WIDTH=4 and WIDTH=1 driven in lockstep;
// the WIDTH=1 copy sees bit 0 of each beat.
module tb_tdm_demux8;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       frame_sync;

  logic [3:0] w4_d [8];
  logic       w4_fd, w4_se, w4_lk;
  logic [2:0] w4_sel;
  logic       w1_d [8];
  logic       w1_fd, w1_se, w1_lk;
  logic [2:0] w1_sel;

  int n_checks = 0;
  int n_fail   = 0;

  tdm_demux8 #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .D0(w4_d[0]), .D1(w4_d[1]), .D2(w4_d[2]), .D3(w4_d[3]),
    .D4(w4_d[4]), .D5(w4_d[5]), .D6(w4_d[6]), .D7(w4_d[7]),
    .frame_done(w4_fd), .sel(w4_sel), .locked(w4_lk), .sync_error(w4_se)
  );

  tdm_demux8 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid), .frame_sync(frame_sync),
    .D0(w1_d[0]), .D1(w1_d[1]), .D2(w1_d[2]), .D3(w1_d[3]),
    .D4(w1_d[4]), .D5(w1_d[5]), .D6(w1_d[6]), .D7(w1_d[7]),
    .frame_done(w1_fd), .sel(w1_sel), .locked(w1_lk), .sync_error(w1_se)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        dv;
    logic        fs;
    logic [3:0]  din;
    logic        fd;
    logic        se;
    logic        lk;
    logic [2:0]  sel;
    logic [31:0] d;   // nibble k = expected Dk
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] FR_A = 32'h0100_1101;  // 1,0,1,1,0,0,1,0
  localparam logic [31:0] FR_C = 32'h1001_0110;  // 0,1,1,0,1,0,0,1
  localparam logic [31:0] FR_E = 32'h1111_1110;  // 0,1,1,1,1,1,1,1
  localparam logic [31:0] FR_B = 32'h7654_3210;  // 0x0..0x7

  task automatic add(input logic r, input logic dv, input logic fs, input logic [3:0] di,
                     input logic fd, input logic se, input logic lk, input logic [2:0] s,
                     input logic [31:0] d);
    vec_t v;
    v.rst = r; v.dv = dv; v.fs = fs; v.din = di;
    v.fd = fd; v.se = se; v.lk = lk; v.sel = s; v.d = d;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL row %0d %s: got %0h want %0h", row, name, got, want);
    end
  endtask

  function automatic logic [7:0] bit0_of(input logic [31:0] d);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = d[4*k];
    return r;
  endfunction

  task automatic apply_row(input int row, input vec_t v);
    logic [31:0] g4;
    logic [7:0]  g1;
    @(negedge clk);
    rst = v.rst; din_valid = v.dv; frame_sync = v.fs; din = v.din;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      g4[4*k +: 4] = w4_d[k];
      g1[k]        = w1_d[k];
    end
    chk("w4_frame_done", row, 32'(w4_fd), 32'(v.fd));
    chk("w4_sync_error", row, 32'(w4_se), 32'(v.se));
    chk("w4_locked",     row, 32'(w4_lk), 32'(v.lk));
    chk("w4_sel",        row, 32'(w4_sel), 32'(v.sel));
    chk("w4_D",          row, g4, v.d);
    chk("w1_frame_done", row, 32'(w1_fd), 32'(v.fd));
    chk("w1_sync_error", row, 32'(w1_se), 32'(v.se));
    chk("w1_locked",     row, 32'(w1_lk), 32'(v.lk));
    chk("w1_sel",        row, 32'(w1_sel), 32'(v.sel));
    chk("w1_D",          row, 32'(g1), 32'(bit0_of(v.d)));
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;

    // Reset, including reset overriding a synced valid beat
    add(1,0,0,4'h0, 0,0,0,3'd0, 32'h0);
    add(1,1,1,4'h3, 0,0,0,3'd0, 32'h0);
    // Back-to-back frame A
    add(0,1,1,4'h1, 0,0,1,3'd1, 32'h0);
    add(0,1,0,4'h0, 0,0,1,3'd2, 32'h0);
    add(0,1,0,4'h1, 0,0,1,3'd3, 32'h0);
    add(0,1,0,4'h1, 0,0,1,3'd4, 32'h0);
    add(0,1,0,4'h0, 0,0,1,3'd5, 32'h0);
    add(0,1,0,4'h0, 0,0,1,3'd6, 32'h0);
    add(0,1,0,4'h1, 0,0,1,3'd7, 32'h0);
    add(0,1,0,4'h0, 1,0,1,3'd0, FR_A);
    add(0,0,0,4'h0, 0,0,1,3'd0, FR_A);
    // Frame A again with gaps after slots 2 and 5 (gaps carry junk and frame_sync)
    add(0,1,1,4'h1, 0,0,1,3'd1, FR_A);
    add(0,1,0,4'h0, 0,0,1,3'd2, FR_A);
    add(0,1,0,4'h1, 0,0,1,3'd3, FR_A);
    add(0,0,1,4'hf, 0,0,1,3'd3, FR_A);
    add(0,1,0,4'h1, 0,0,1,3'd4, FR_A);
    add(0,1,0,4'h0, 0,0,1,3'd5, FR_A);
    add(0,1,0,4'h0, 0,0,1,3'd6, FR_A);
    add(0,0,0,4'h1, 0,0,1,3'd6, FR_A);
    add(0,0,1,4'h1, 0,0,1,3'd6, FR_A);
    add(0,0,0,4'hf, 0,0,1,3'd6, FR_A);
    add(0,1,0,4'h1, 0,0,1,3'd7, FR_A);
    add(0,1,0,4'h0, 1,0,1,3'd0, FR_A);
    // Missing sync after a good frame -> HUNT, D holds
    add(0,1,0,4'h1, 0,1,0,3'd0, FR_A);
    add(0,0,0,4'h0, 0,0,0,3'd0, FR_A);
    // Five unsynced beats ignored in HUNT, then frame C
    for (int i = 0; i < 5; i++) add(0,1,0,4'h1, 0,0,0,3'd0, FR_A);
    add(0,1,1,4'h0, 0,0,1,3'd1, FR_A);
    add(0,1,0,4'h1, 0,0,1,3'd2, FR_A);
    add(0,1,0,4'h1, 0,0,1,3'd3, FR_A);
    add(0,1,0,4'h0, 0,0,1,3'd4, FR_A);
    add(0,1,0,4'h1, 0,0,1,3'd5, FR_A);
    add(0,1,0,4'h0, 0,0,1,3'd6, FR_A);
    add(0,1,0,4'h0, 0,0,1,3'd7, FR_A);
    add(0,1,0,4'h1, 1,0,1,3'd0, FR_C);
    // Early sync on 4th beat, then 7 beats complete frame E
    add(0,1,1,4'h1, 0,0,1,3'd1, FR_C);
    add(0,1,0,4'h1, 0,0,1,3'd2, FR_C);
    add(0,1,0,4'h1, 0,0,1,3'd3, FR_C);
    add(0,1,1,4'h0, 0,1,1,3'd1, FR_C);
    for (int s = 1; s < 7; s++) add(0,1,0,4'h1, 0,0,1,3'(s+1), FR_C);
    add(0,1,0,4'h1, 1,0,1,3'd0, FR_E);
    // Next frame starts in the frame_done cycle; reset hits at slot 5
    add(0,1,1,4'h9, 0,0,1,3'd1, FR_E);
    add(0,1,0,4'ha, 0,0,1,3'd2, FR_E);
    add(0,1,0,4'hb, 0,0,1,3'd3, FR_E);
    add(0,1,0,4'hc, 0,0,1,3'd4, FR_E);
    add(0,1,0,4'hd, 0,0,1,3'd5, FR_E);
    add(1,1,0,4'he, 0,0,0,3'd0, 32'h0);
    // After release an unsynced beat must be ignored, then frame B
    add(0,1,0,4'h5, 0,0,0,3'd0, 32'h0);
    add(0,1,1,4'h0, 0,0,1,3'd1, 32'h0);
    for (int s = 1; s < 7; s++) add(0,1,0,4'(s), 0,0,1,3'(s+1), 32'h0);
    add(0,1,0,4'h7, 1,0,1,3'd0, FR_B);
    add(0,0,0,4'h0, 0,0,1,3'd0, FR_B);
    add(0,0,1,4'h3, 0,0,1,3'd0, FR_B);

    for (int i = 0; i < vecs.size(); i++) apply_row(i, vecs[i]);

    // Early sync landing on slot 7 must raise sync_error, never frame_done
    begin
      vec_t v;
      add(0,1,1,4'h2, 0,0,1,3'd1, FR_B);
      for (int s = 1; s < 7; s++) add(0,1,0,4'h8, 0,0,1,3'(s+1), FR_B);
      add(0,1,1,4'h4, 0,1,1,3'd1, FR_B);
      for (int i = vecs.size() - 8; i < vecs.size(); i++) begin
        v = vecs[i];
        apply_row(i, v);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 Parameter: WIDTH, default 1, bits carried per time slot (legal range 1..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 din  input  WIDTH  serial TDM data; one slot value per valid cycle.
REQ-005 din_valid  input  1  din carries a slot value this cycle.
REQ-006 frame_sync  input  1  qualifies the din beat as slot 0; ignored when din_valid=0.
REQ-007 D0..D7  output  WIDTH each  registered slot outputs; Dk holds slot k of the last completed frame.
REQ-008 frame_done  output  1  one-cycle pulse, D0..D7 updated this cycle.
REQ-009 sel  output  3  index of the next expected slot; bit 2 corresponds to mux select S0, bit 0 to S2.
REQ-010 locked  output  1  high while in state RECV.
REQ-011 sync_error  output  1  one-cycle pulse on a framing violation.

Function
REQ-012 Slot k (k=0..7) SHALL be routed to Dk, so that sel={S0,S1,S2}=k of the matching 8:1 mux.
REQ-013 The block SHALL use two states: HUNT and RECV.
REQ-014 In HUNT, beats with din_valid=1 and frame_sync=0 SHALL be discarded, with sel held at 0.
REQ-015 In HUNT, a beat with din_valid=1 and frame_sync=1 SHALL be stored as slot 0, set sel=1, and move to RECV.
REQ-016 In RECV, each beat with din_valid=1 and frame_sync=0 SHALL be stored in staging slot sel, and sel SHALL increment.
REQ-017 Cycles with din_valid=0 SHALL change no state, counter or staging register. Gaps of any length are legal.
REQ-018 On the slot-7 beat, the block SHALL transfer all eight staging values to D0..D7 in the next cycle (1-cycle latency from the slot-7 edge).
REQ-019 frame_done SHALL pulse in that same next cycle, and D0..D7 SHALL then hold until the next completed frame.
REQ-020 After slot 7, sel SHALL wrap to 0 and the block SHALL stay in RECV, expecting frame_sync on the next beat.
REQ-021 In RECV, a beat with sel=0 and frame_sync=0 SHALL be a missing-sync error: pulse sync_error, discard the beat, and go to HUNT.
REQ-022 In RECV, a beat with sel!=0 and frame_sync=1 SHALL be an early-sync error: pulse sync_error, discard the partial frame, and store this beat as slot 0 with sel=1, staying in RECV.
REQ-023 A partial frame SHALL never reach D0..D7, and no frame_done SHALL be issued for it.
REQ-024 When a frame completes and the next beat arrives in the same cycle, frame_done/D update and the next-frame slot-0 capture SHALL both take effect.
REQ-025 sync_error and frame_done SHALL be mutually exclusive within a cycle.

Reset
REQ-026 While rst=1, the state SHALL be HUNT; sel, D0..D7 and staging SHALL be 0; frame_done, sync_error and locked SHALL be 0. rst SHALL override all other inputs.
REQ-027 A reset asserted mid-frame SHALL discard the partial frame, and the first frame after release SHALL require frame_sync.

Verification
REQ-028 WIDTH=1; rst, then 8 back-to-back valid beats 1,0,1,1,0,0,1,0 with frame_sync on the first beat -> one cycle after the 8th beat, D0..D7=1,0,1,1,0,0,1,0, frame_done pulses once, and locked=1.
REQ-029 The same frame with din_valid=0 gaps of 1 and 3 cycles inserted after slots 2 and 5 -> identical D values, with frame_done 1 cycle after the last valid beat.
REQ-030 In HUNT, 5 valid beats without frame_sync, then a synced frame -> the first 5 beats are ignored, and only the synced frame appears on D.
REQ-031 frame_sync on the 4th beat of a frame -> sync_error pulses, D unchanged, sel=1 next cycle; the following 7 beats complete a frame and frame_done pulses.
REQ-032 After a good frame, the next beat has frame_sync=0 -> sync_error, state HUNT, locked=0, D still holding the previous frame.
REQ-033 WIDTH=4; rst asserted at slot 5 and then released, followed by a synced frame 0x0..0x7 -> D0..D7=0x0..0x7 with no stale data, and exactly one frame_done.
